// File: rtl/pe_operand_feeder.sv
// Operand feeder for the convolution PE: streams patch/filter chunks from two
// 1-cycle-latency read ports and emits accum/en aligned to the adder-tree depth.
module pe_operand_feeder #(
  parameter int unsigned LENGTH  = 16,
  parameter int unsigned INT8    = 8,
  parameter int unsigned AW      = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned ACC_DLY = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_chunks,
  input  logic [AW-1:0]          base_a,
  input  logic [AW-1:0]          base_b,
  output logic                   rd_en_a,
  output logic [AW-1:0]          rd_addr_a,
  input  logic [LENGTH*INT8-1:0] rd_data_a,
  output logic                   rd_en_b,
  output logic [AW-1:0]          rd_addr_b,
  input  logic [LENGTH*INT8-1:0] rd_data_b,
  output logic [LENGTH*INT8-1:0] in_a,
  output logic [LENGTH*INT8-1:0] in_b,
  output logic                   accum,
  output logic                   en,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DW = LENGTH * INT8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   n_q;
  logic [CNT_W-1:0]   k_q;
  logic [AW-1:0]      base_a_q;
  logic [AW-1:0]      base_b_q;

  // Read-return stage tags (chunk k sits here in cycle 2+k)
  logic               rd_vld;
  logic               rd_acc;
  logic               rd_fin;

  // Tag shift register: bit i holds the chunk that was on in_a/in_b i cycles ago
  logic [ACC_DLY-1:0] sr_vld;
  logic [ACC_DLY-1:0] sr_acc;
  logic [ACC_DLY-1:0] sr_en;

  logic               last_issue_c;
  logic               pipe_busy_c;

  assign last_issue_c = (k_q == n_q - CNT_W'(1));
  assign pipe_busy_c  = rd_en_a | rd_vld | (|sr_vld);

  // Job control: address issue and completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      n_q       <= '0;
      k_q       <= '0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      rd_en_a   <= 1'b0;
      rd_en_b   <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (num_chunks != '0) begin
              n_q       <= num_chunks;
              base_a_q  <= base_a;
              base_b_q  <= base_b;
              k_q       <= '0;
              rd_en_a   <= 1'b1;
              rd_en_b   <= 1'b1;
              rd_addr_a <= base_a;
              rd_addr_b <= base_b;
              busy      <= 1'b1;
              state     <= ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (last_issue_c) begin
            rd_en_a   <= 1'b0;
            rd_en_b   <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            state     <= DRAIN;
          end else begin
            k_q       <= k_q + CNT_W'(1);
            rd_addr_a <= base_a_q + AW'(k_q + CNT_W'(1));
            rd_addr_b <= base_b_q + AW'(k_q + CNT_W'(1));
          end
        end
        DRAIN: begin
          // Final chunk is in the accum/en register once everything upstream is empty
          if (!pipe_busy_c) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture and control-tag pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld <= 1'b0;
      rd_acc <= 1'b0;
      rd_fin <= 1'b0;
      in_a   <= '0;
      in_b   <= '0;
      sr_vld <= '0;
      sr_acc <= '0;
      sr_en  <= '0;
      accum  <= 1'b0;
      en     <= 1'b0;
    end else begin
      rd_vld <= rd_en_a;
      rd_acc <= rd_en_a & (k_q != '0);
      rd_fin <= rd_en_a & last_issue_c;
      in_a   <= rd_vld ? rd_data_a : DW'(0);
      in_b   <= rd_vld ? rd_data_b : DW'(0);
      sr_vld <= ACC_DLY'({sr_vld, rd_vld});
      sr_acc <= ACC_DLY'({sr_acc, rd_vld & rd_acc});
      sr_en  <= ACC_DLY'({sr_en, rd_vld & rd_fin});
      accum  <= sr_acc[ACC_DLY-1];
      en     <= sr_en[ACC_DLY-1];
    end
  end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Self-checking bench for pe_operand_feeder: per-cycle timeline model built
// from the job timing rules, directed vector table, and randomized jobs.
module tb_pe_operand_feeder;

  localparam int unsigned LENGTH  = 16;
  localparam int unsigned INT8    = 8;
  localparam int unsigned AW      = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ACC_DLY = 5;
  localparam int unsigned DW      = LENGTH * INT8;
  localparam int          MAXC    = 8192;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  num_chunks = '0;
  logic [AW-1:0]     base_a = '0;
  logic [AW-1:0]     base_b = '0;
  logic              rd_en_a, rd_en_b;
  logic [AW-1:0]     rd_addr_a, rd_addr_b;
  logic [DW-1:0]     rd_data_a, rd_data_b;
  logic [DW-1:0]     in_a, in_b;
  logic              accum, en, busy, done;

  pe_operand_feeder #(
    .LENGTH(LENGTH), .INT8(INT8), .AW(AW), .CNT_W(CNT_W), .ACC_DLY(ACC_DLY)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_chunks(num_chunks),
    .base_a(base_a), .base_b(base_b),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .in_a(in_a), .in_b(in_b), .accum(accum), .en(en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Buffers with 1-cycle read latency; junk on the bus when not reading
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? mem_a[rd_addr_a] : {4{$urandom()}};
    rd_data_b <= rd_en_b ? mem_b[rd_addr_b] : {4{$urandom()}};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int c, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  // Expected per-cycle timeline
  bit          e_rd   [MAXC];
  bit [AW-1:0] e_aa   [MAXC];
  bit [AW-1:0] e_ab   [MAXC];
  bit [DW-1:0] e_ina  [MAXC];
  bit [DW-1:0] e_inb  [MAXC];
  bit          e_acc  [MAXC];
  bit          e_en   [MAXC];
  bit          e_busy [MAXC];
  bit          e_done [MAXC];
  int          model_free = MAXC;

  // Observed values for the directed checks
  bit          o_en   [MAXC];
  bit          o_done [MAXC];
  bit          o_rd   [MAXC];
  bit          o_busy [MAXC];
  bit [AW-1:0] o_aa   [MAXC];
  bit [DW-1:0] o_ina  [MAXC];
  bit [DW-1:0] o_inb  [MAXC];

  // Start sampled at the end of cycle c; its cycle 1 is c+1
  task automatic model_start(input int c, input int n, input int ba, input int bb);
    if (c < model_free) return;
    if (n == 0) begin
      e_done[c+1] = 1'b1;
      model_free = c + 1;
      return;
    end
    for (int j = 0; j < n; j++) begin
      e_rd[c+1+j]          = 1'b1;
      e_aa[c+1+j]          = AW'((ba + j) % 256);
      e_ab[c+1+j]          = AW'((bb + j) % 256);
      e_ina[c+3+j]         = mem_a[(ba + j) % 256];
      e_inb[c+3+j]         = mem_b[(bb + j) % 256];
      e_acc[c+3+ACC_DLY+j] = (j != 0);
      e_en[c+3+ACC_DLY+j]  = (j == n - 1);
    end
    for (int t = c + 1; t <= c + n + 2 + ACC_DLY; t++) e_busy[t] = 1'b1;
    e_done[c+n+3+ACC_DLY] = 1'b1;
    model_free = c + n + 3 + ACC_DLY;
  endtask

  task automatic model_reset(input int c);
    for (int t = c; t < MAXC; t++) begin
      e_rd[t] = 0; e_aa[t] = '0; e_ab[t] = '0; e_ina[t] = '0; e_inb[t] = '0;
      e_acc[t] = 0; e_en[t] = 0; e_busy[t] = 0; e_done[t] = 0;
    end
    model_free = MAXC;
  endtask

  // Continuous checker, sampling mid-cycle
  always @(negedge clk) begin
    int c;
    c = cyc;
    if (c < MAXC) begin
      o_en[c] = en; o_done[c] = done; o_rd[c] = rd_en_a; o_busy[c] = busy;
      o_aa[c] = rd_addr_a; o_ina[c] = in_a; o_inb[c] = in_b;
      chk("rd_en_a", c, DW'(rd_en_a), DW'(e_rd[c]));
      chk("rd_en_b", c, DW'(rd_en_b), DW'(e_rd[c]));
      if (e_rd[c]) begin
        chk("rd_addr_a", c, DW'(rd_addr_a), DW'(e_aa[c]));
        chk("rd_addr_b", c, DW'(rd_addr_b), DW'(e_ab[c]));
      end
      chk("in_a", c, in_a, e_ina[c]);
      chk("in_b", c, in_b, e_inb[c]);
      chk("accum", c, DW'(accum), DW'(e_acc[c]));
      chk("en", c, DW'(en), DW'(e_en[c]));
      chk("busy", c, DW'(busy), DW'(e_busy[c]));
      chk("done", c, DW'(done), DW'(e_done[c]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n, input int ba, input int bb);
    start = 1'b1;
    num_chunks = CNT_W'(n);
    base_a = AW'(ba);
    base_b = AW'(bb);
    model_start(cyc, n, ba, bb);
    step();
    start = 1'b0;
    num_chunks = CNT_W'($urandom());
    base_a = AW'($urandom());
    base_b = AW'($urandom());
  endtask

  task automatic do_job(input int n, input int ba, input int bb, input int gap,
                        input bit stray, output int c0);
    int guard;
    guard = 0;
    while (cyc < model_free + gap && guard < 2000) begin
      step();
      guard++;
    end
    if (guard >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle: got timeout expected idle within 2000 cycles");
    end
    c0 = cyc;
    pulse_start(n, ba, bb);
    if (stray && n > 0) begin
      repeat ($urandom_range(0, n + 1)) step();
      pulse_start($urandom_range(0, 20), $urandom_range(0, 255), $urandom_range(0, 255));
    end
  endtask

  typedef struct {
    int n; int ba; int bb;
    int en_rel; int en_cnt; int done_rel; int rd_cnt; int busy_cnt;
  } vec_t;

  task automatic run_directed(input vec_t v, output int c0);
    int first_en, cnt_en, first_done, cnt_rd, cnt_busy;
    do_job(v.n, v.ba, v.bb, 2, 1'b0, c0);
    while (cyc < c0 + v.n + ACC_DLY + 7) step();
    first_en = -1; cnt_en = 0; first_done = -1; cnt_rd = 0; cnt_busy = 0;
    for (int r = 1; r <= v.n + ACC_DLY + 5; r++) begin
      if (o_en[c0+r]) begin
        cnt_en++;
        if (first_en < 0) first_en = r;
      end
      if (o_done[c0+r] && first_done < 0) first_done = r;
      if (o_rd[c0+r]) cnt_rd++;
      if (o_busy[c0+r]) cnt_busy++;
    end
    chk($sformatf("dir_n%0d_en_cycle", v.n), c0, DW'(first_en), DW'(v.en_rel));
    chk($sformatf("dir_n%0d_en_count", v.n), c0, DW'(cnt_en), DW'(v.en_cnt));
    chk($sformatf("dir_n%0d_done_cycle", v.n), c0, DW'(first_done), DW'(v.done_rel));
    chk($sformatf("dir_n%0d_rd_count", v.n), c0, DW'(cnt_rd), DW'(v.rd_cnt));
    chk($sformatf("dir_n%0d_busy_count", v.n), c0, DW'(cnt_busy), DW'(v.busy_cnt));
  endtask

  initial begin
    vec_t vecs [5];
    int c0, cr, bad;
    vecs[0] = '{n:1, ba:8'h00, bb:8'h00, en_rel:8,  en_cnt:1, done_rel:9,  rd_cnt:1, busy_cnt:8};
    vecs[1] = '{n:3, ba:8'h10, bb:8'h40, en_rel:10, en_cnt:1, done_rel:11, rd_cnt:3, busy_cnt:10};
    vecs[2] = '{n:2, ba:8'hFF, bb:8'h20, en_rel:9,  en_cnt:1, done_rel:10, rd_cnt:2, busy_cnt:9};
    vecs[3] = '{n:0, ba:8'h33, bb:8'h44, en_rel:-1, en_cnt:0, done_rel:1,  rd_cnt:0, busy_cnt:0};
    vecs[4] = '{n:4, ba:8'hFE, bb:8'h7E, en_rel:11, en_cnt:1, done_rel:12, rd_cnt:4, busy_cnt:11};

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_b[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    mem_a[0] = {LENGTH{8'h01}};
    mem_b[0] = {LENGTH{8'h02}};

    repeat (3) step();
    reset = 1'b1;
    model_free = cyc;
    step();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_directed(vecs[i], c0);
      if (i == 0) begin
        chk("single_in_a", c0 + 3, o_ina[c0+3], {LENGTH{8'h01}});
        chk("single_in_b", c0 + 3, o_inb[c0+3], {LENGTH{8'h02}});
      end
      if (i == 2) begin
        chk("wrap_addr0", c0 + 1, DW'(o_aa[c0+1]), DW'(8'hFF));
        chk("wrap_addr1", c0 + 2, DW'(o_aa[c0+2]), DW'(8'h00));
      end
    end

    // Ignored start during an N=2 job, then back-to-back N=2 jobs
    do_job(2, 8'h80, 8'h90, 1, 1'b1, c0);
    do_job(2, 8'h05, 8'h06, 0, 1'b0, c0);
    do_job(2, 8'h07, 8'h08, 0, 1'b0, cr);
    chk("b2b_start_gap", cr, DW'(cr - c0), DW'(2 + 3 + ACC_DLY));

    // Reset mid-job abandons it
    do_job(4, 8'h30, 8'h50, 2, 1'b0, c0);
    while (cyc < c0 + 4) step();
    reset = 1'b0;
    model_reset(cyc);
    repeat (3) step();
    reset = 1'b1;
    model_free = cyc;
    bad = 0;
    for (int t = c0 + 4; t < cyc; t++) bad += int'(o_en[t]) + int'(o_done[t]) + int'(o_busy[t]);
    chk("reset_abandon", c0, DW'(bad), DW'(0));
    run_directed(vecs[0], c0);

    // Randomized jobs, including zero-length, stray starts and back-to-back
    for (int i = 0; i < 40; i++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
      do_job(n, $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), c0);
    end

    while (cyc < model_free + 4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
